// File: rtl/div_sequencer.sv
`default_nettype none
// div_sequencer: radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with pipeline stall enables.
// Revision: 1.0

module div_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            f_to_d_enable_ff,
  output logic            d_to_e_enable_ff,
  output logic            e_to_m_enable_ff
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q, quo_q, dsr_q;
  logic             q_neg, r_neg, op_rem_q;

  logic            op_signed, op_rem, div_zero, overflow, accept, calc_last, stall;
  logic [XLEN-1:0] abs_dividend, abs_divisor;
  logic [XLEN:0]   trial, diff;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, rem_final, quo_final;

  // Codes outside the M-extension divide group fall back to DIVU.
  assign op_signed = (funct3 == 3'b100) || (funct3 == 3'b110);
  assign op_rem    = (funct3 == 3'b110) || (funct3 == 3'b111);

  assign abs_dividend = (op_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign abs_divisor  = (op_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  assign div_zero = (divisor == '0);
  assign overflow = op_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign accept   = (state == IDLE) && start && !flush;

  // One restoring step: shift in the next dividend bit and keep the difference when it fits.
  assign trial     = {rem_q, quo_q[XLEN-1]};
  assign diff      = trial - {1'b0, dsr_q};
  assign ge        = !diff[XLEN];
  assign rem_step  = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_step  = {quo_q[XLEN-2:0], ge};
  assign rem_final = r_neg ? -rem_step : rem_step;
  assign quo_final = q_neg ? -quo_step : quo_step;
  assign calc_last = (state == CALC) && (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = (div_zero || overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (calc_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      stall      = 1'b0;
    end
  end

  assign f_to_d_enable_ff = !stall;
  assign d_to_e_enable_ff = !stall;
  assign e_to_m_enable_ff = !stall;
  assign result_valid     = (state == DONE);
  assign busy             = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      op_rem_q <= 1'b0;
      result   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rem_q    <= '0;
        quo_q    <= abs_dividend;
        dsr_q    <= abs_divisor;
        q_neg    <= op_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        r_neg    <= op_signed && dividend[XLEN-1];
        op_rem_q <= op_rem;
        cnt      <= '0;
        // Special cases resolve immediately; the datapath is loaded but never iterated.
        if (div_zero)      result <= op_rem ? dividend : '1;
        else if (overflow) result <= op_rem ? '0 : dividend;
      end else if ((state == CALC) && !flush) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt   <= cnt + CNT_W'(1);
        if (calc_last) result <= op_rem_q ? rem_final : quo_final;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// tb_div_sequencer: scoreboard bench for div_sequencer against an arithmetic reference model.

module tb_div_sequencer;
  localparam int XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dividend, divisor, result;
  logic            result_valid, busy, f_en, d_en, e_en;

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .result(result), .result_valid(result_valid), .busy(busy),
    .f_to_d_enable_ff(f_en), .d_to_e_enable_ff(d_en), .e_to_m_enable_ff(e_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V divide semantics expressed directly with / and %.
  function automatic logic [63:0] ref_div(logic [2:0] f3, logic [63:0] a, logic [63:0] b);
    logic               sgn, rm;
    logic signed [63:0] sa, sb_;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    rm  = (f3 == 3'b110) || (f3 == 3'b111);
    sa  = a;
    sb_ = b;
    if (b == 64'd0) return rm ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (sgn) begin
      if (a == MINV && b == 64'hFFFF_FFFF_FFFF_FFFF) return rm ? 64'd0 : a;
      return rm ? 64'(sa % sb_) : 64'(sa / sb_);
    end
    return rm ? (a % b) : (a / b);
  endfunction

  function automatic int latency(logic [2:0] f3, logic [63:0] a, logic [63:0] b);
    logic sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    if (b == 64'd0) return 1;
    if (sgn && a == MINV && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got result_valid=1 with %h, expected none (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("valid_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(logic [2:0] f3, logic [63:0] a, logic [63:0] b, bit gap);
    int          t, lat;
    logic [63:0] exp;
    funct3   = f3;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    t   = cyc;
    exp = ref_div(f3, a, b);
    lat = latency(f3, a, b);
    sb.push_back('{exp, t + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("enables", 64'({f_en, d_en, e_en}), (k < lat) ? 64'd0 : 64'd7);
      check("busy", 64'(busy), (k > 0) ? 64'd1 : 64'd0);
      step();
    end
    start = 1'b0;
    if (gap) begin
      @(negedge clk);
      check("result_hold", result, exp);
      check("busy_idle", 64'(busy), 64'd0);
      step();
    end
  endtask

  task automatic abort_test(bit use_rst, int at);
    funct3   = 3'b101;
    dividend = 64'd1000;
    divisor  = 64'd3;
    start    = 1'b1;
    for (int k = 0; k < at; k++) begin
      @(negedge clk);
      check("abort_enables", 64'({f_en, d_en, e_en}), 64'd0);
      step();
    end
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    if (!use_rst) begin
      @(negedge clk);
      check("flush_enables", 64'({f_en, d_en, e_en}), 64'd7);
    end
    step();
    rst   = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(result_valid), 64'd0);
    check("abort_enables_after", 64'({f_en, d_en, e_en}), 64'd7);
    if (use_rst) check("rst_result", result, 64'd0);
    step();
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 50));
      2:       return MINV;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      4:       return -64'($urandom_range(1, 50));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; dividend = '0; divisor = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_enables", 64'({f_en, d_en, e_en}), 64'd7);
    step();

    do_div(3'b101, 64'd100, 64'd7, 1'b1);
    do_div(3'b111, 64'd100, 64'd7, 1'b1);
    do_div(3'b100, -64'd7, 64'd2, 1'b0);
    do_div(3'b110, -64'd7, 64'd2, 1'b1);
    do_div(3'b110, 64'd7, -64'd2, 1'b1);
    do_div(3'b101, 64'd5, 64'd0, 1'b1);
    do_div(3'b110, 64'd5, 64'd0, 1'b0);
    do_div(3'b100, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    do_div(3'b110, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    abort_test(1'b0, 10);
    do_div(3'b101, 64'd9, 64'd3, 1'b1);
    abort_test(1'b1, 20);

    start = 1'b1; flush = 1'b1; funct3 = 3'b101;
    dividend = 64'd50; divisor = 64'd5;
    @(negedge clk);
    check("start_flush_enables", 64'({f_en, d_en, e_en}), 64'd7);
    step();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 64'(busy), 64'd0);
    step();

    for (int i = 0; i < 20; i++) begin
      logic [2:0]  f3;
      logic [63:0] a, b;
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a  = rnd_op();
      b  = rnd_op();
      do_div(f3, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (4) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divide sequencer for the M extension, sitting beside the ALU in the execute stage. Accepts DIV/DIVU/REM/REMU when the instruction reaches execute, holds the front of the pipeline with the same stall enables used by the hazard logic, runs a radix-2 restoring division, and releases the result for capture into the execute-to-memory register. RISC-V divide-by-zero and signed-overflow results are produced without iterating.

## Interface
- XLEN, 64, operand/result width
- CNT_W, $clog2(XLEN)+1, iteration counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  divide instruction valid in execute, held high while the instruction remains there
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes treated as DIVU
- dividend  in  XLEN  rs1 operand, after forwarding
- divisor  in  XLEN  rs2 operand, after forwarding
- flush  in  1  kill the in-flight divide (branch/jump redirect)
- result  out  XLEN  quotient or remainder, valid when result_valid
- result_valid  out  1  one-cycle strobe; execute-to-memory register captures result this cycle
- busy  out  1  state != IDLE
- f_to_d_enable_ff  out  1  fetch-to-decode flop enable (0 = stall)
- d_to_e_enable_ff  out  1  decode-to-execute flop enable (0 = stall)
- e_to_m_enable_ff  out  1  execute-to-memory flop enable (0 = hold bubble)

## Operation
- States: IDLE, CALC, DONE. Reset: state IDLE; result 0; result_valid 0; busy 0; counter 0; all three enables 1.
- IDLE: on start && !flush, latch |dividend|, |divisor| (absolute values for DIV/REM; raw for DIVU/REMU), quotient-negate flag (signs differ, signed op), remainder-negate flag (dividend negative, signed op), op select; clear partial remainder, counter = 0.
  - divisor == 0 -> DONE; result = all ones (div) or dividend (rem).
  - signed op, dividend == 1 followed by XLEN-1 zeros (most negative), divisor == all ones -> DONE; result = dividend (DIV) or 0 (REM).
  - otherwise -> CALC.
- CALC: each cycle shift {rem, quo} left one bit, bring in the next dividend MSB, trial-subtract the divisor, and keep the difference with quotient bit 1 if non-negative; the subtraction is XLEN+1 bits wide. Counter increments; at counter == XLEN-1 -> DONE, with the final result (sign-corrected by the negate flags) registered on that transition.
- DONE: result_valid = 1; -> IDLE unconditionally. start is ignored in DONE (same instruction still present).
- Stall: f_to_d_enable_ff = d_to_e_enable_ff = e_to_m_enable_ff = 0 when (state == IDLE && start && !flush) or state == CALC; 1 otherwise, including DONE. The enables are combinational from state and inputs.
- flush (any state): next state IDLE, result_valid 0 next cycle, enables 1 in the flush cycle; flush wins over start in the same cycle.
- rst mid-CALC: same as power-on reset next cycle; partial results discarded.

## Timing
- Start cycle T (IDLE, start high): enables low.
- Normal op: CALC during T+1 .. T+XLEN; DONE at T+XLEN+1 with result_valid high and enables high. Stall length XLEN+1 cycles.
- Special case (div by zero, overflow): DONE at T+1. Stall length 1 cycle.
- Back-to-back divides: the second instruction enters execute at T+XLEN+2 (IDLE) and starts immediately; there is no dead cycle beyond DONE.
- result holds its value after DONE until the next DONE or reset.
- busy is high from T+1 through DONE.

## Test plan
- XLEN=64, DIVU 100/7, start held -> enables low for 65 cycles; result_valid exactly at T+65 with result 14; REMU same operands -> 2.
- DIV -7/2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); REM 7/-2 -> 1.
- DIVU 5/0 -> result all ones at T+1; REM 5/0 -> 5; stall exactly one cycle.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 at T+1; REM same -> 0.
- flush asserted at T+10 during CALC -> state IDLE, busy 0, and enables 1 from T+10; no result_valid pulse; the next start computes 9/3 = 3 correctly.
- rst at T+20 -> IDLE at T+21, result 0, result_valid 0; start with flush in the same cycle in IDLE -> no stall, busy stays 0.
